// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle radix-2^B shift-add multiplier with start/busy/done handshake
module seq_multiplier #(
  parameter int N = 32,
  parameter int B = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] out
);

  localparam int ITER = N / B;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, next_state;
  logic [2*N-1:0]   acc, acc_next, mcand_sh, prod;
  logic [N-1:0]     mult_mag, a_mag, b_mag;
  logic [CW-1:0]    count;
  logic             neg;
  logic             accept;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);

  // Magnitudes are N-bit unsigned, so the most negative value maps to 2^(N-1).
  assign a_mag = (signed_mode && multiplicand[N-1]) ? -multiplicand : multiplicand;
  assign b_mag = (signed_mode && multiplier[N-1])   ? -multiplier   : multiplier;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (count == LAST) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // mcand_sh carries mcand_mag << (count*B), so each digit needs only fixed shifts.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < B; i++) begin
      if (mult_mag[i]) acc_next = acc_next + (mcand_sh << i);
    end
  end

  assign prod = neg ? -acc : acc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      mcand_sh <= '0;
      mult_mag <= '0;
      count    <= '0;
      neg      <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
    end else begin
      done <= (state == FINISH);
      if (accept) begin
        neg      <= signed_mode & (multiplicand[N-1] ^ multiplier[N-1]);
        mcand_sh <= {{N{1'b0}}, a_mag};
        mult_mag <= b_mag;
        acc      <= '0;
        count    <= '0;
      end else if (state == RUN) begin
        acc      <= acc_next;
        mcand_sh <= mcand_sh << B;
        mult_mag <= mult_mag >> B;
        count    <= count + 1'b1;
      end else if (state == FINISH) begin
        out <= prod;
      end
    end
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised multi-cycle shift-add multiplier; successor to the single-mode accumulator multiplier.
- Adds an explicit start/busy/done handshake, a per-operation signed/unsigned mode, and a configurable number of multiplier bits retired per cycle (radix 2^B).
- Used wherever area matters more than latency and a full combinational array multiplier is not justified.

Parameters:
N, 32, operand width in bits; must be at least 2
B, 1, multiplier bits consumed per cycle; must divide N; iteration count ITER = N/B

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a new multiply; sampled only when not busy
signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; captured with start
multiplicand  input  N  operand A; captured with start
multiplier  input  N  operand B; captured with start
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse marking the cycle in which out becomes valid
out  output  2N  product; holds its value until the next completion

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; busy = 0; done = 0; out = 0.
  - Internal accumulator, counter and operand registers are cleared.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1.
  - FINISH: busy = 1. Lasts one cycle; writes out and raises done.
- IDLE to RUN, on a rising edge with start = 1:
  - Capture signed_mode.
  - Capture operand magnitudes: in signed mode, |x|; otherwise x unchanged.
  - neg = signed_mode and (sign of multiplicand XOR sign of multiplier).
  - Clear the 2N-bit accumulator; counter = 0.
- |x| is formed as an N-bit unsigned value, so -2^(N-1) maps correctly to 2^(N-1).
- RUN, once per cycle:
  - acc += (mcand_mag << (counter*B)) * (low B bits of mult_mag).
  - mult_mag shifts right by B; counter increments.
  - After ITER iterations, go to FINISH.
  - Arithmetic is full 2N-bit width. The unsigned product of magnitudes never overflows 2N bits.
- FINISH:
  - out = neg ? (two's-complement negate of acc) : acc, truncated to 2N bits.
  - done = 1 for exactly this cycle; next state IDLE.
- Latency: with start sampled at edge 0, done is high after edge ITER+1 (default 33 cycles). Latency is fixed and independent of operand values; there is no early termination.
- Back-to-back operation:
  - In FINISH, busy is high and start is ignored.
  - start held high in IDLE begins a new operation on every acceptance edge. Minimum initiation interval is ITER+2 cycles.
- start while busy: ignored. Operand and mode inputs may change freely while busy with no effect on the running operation.
- out changes only in FINISH or on reset. Between operations it holds the last product.
- Unsigned result is correct for the full range, e.g. (2^N-1)^2 = 2^2N - 2^(N+1) + 1.
- Signed result is correct for the full range; the largest result is (-2^(N-1))^2 = 2^(2N-2).
- Zero operands: the result is 0 with no sign artefact, since negating 0 yields 0.

Test Plan:
- Reset and basic unsigned (N=32, B=1):
  - Stimulus: hold reset low, then release; signed_mode=0; start with 134 x 79.
  - Required: busy rises on the edge after start; done pulses exactly 33 cycles after the start edge; out = 10586, held after done drops.
- Unsigned extremes (N=32, B=1):
  - Stimulus: 0 x 0, then 1 x 1, then 0xFFFFFFFF x 0xFFFFFFFF.
  - Required: out = 0, then 1, then 0xFFFFFFFE00000001.
- Signed mode (N=32, B=1):
  - -7 x 7: out = 0xFFFFFFFFFFFFFFCF (-49).
  - -7 x -7: out = 49.
  - 0x80000000 x 0x80000000: out = 0x4000000000000000.
  - 0x80000000 x 1: out = 0xFFFFFFFF80000000.
- Handshake robustness (N=32, B=1):
  - Stimulus: start a 127 x 127 operation; pulse start with 5 x 5 at cycle 10; toggle the operand inputs while busy.
  - Required: no restart; out = 16129 at cycle 33. start held high through done begins the next operation on the IDLE edge after FINISH.
- Reset mid-operation:
  - Stimulus: drive reset low asynchronously at cycle 15 of a run, between clock edges.
  - Required: busy, done and out go to 0 immediately with no further done pulse; a subsequent 3 x 4 returns 12 with normal latency.
- Radix variant (N=32, B=4):
  - Stimulus: 134 x 79 unsigned, then -7 x 7 signed.
  - Required: done after 9 cycles; out = 10586, then 0xFFFFFFFFFFFFFFCF.
  - Also run N=8, B=2 exhaustively over all operand pairs in both modes against a reference product.
